// File: rtl/axis_h2c_byte_unpacker.sv
// Host-to-card AXI-Stream byte unpacker: 64-bit beats in, one kept byte per cycle out.
// Keeps byte and packet statistics counters for CSR readback.
module axis_h2c_byte_unpacker #(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  AXIS_H2C_tdata,
  input  logic [KEEP_WIDTH-1:0]  AXIS_H2C_tkeep,
  input  logic                   AXIS_H2C_tlast,
  input  logic                   AXIS_H2C_tvalid,
  output logic                   AXIS_H2C_tready,
  output logic [7:0]             BYTE_tdata,
  output logic                   BYTE_tlast,
  output logic                   BYTE_tvalid,
  input  logic                   BYTE_tready,
  input  logic                   stats_clear,
  output logic [COUNT_WIDTH-1:0] byte_count,
  output logic [COUNT_WIDTH-1:0] packet_count
);

  logic [DATA_WIDTH-1:0] hold_data;
  logic [KEEP_WIDTH-1:0] remaining;
  logic [KEEP_WIDTH-1:0] lowest_bit;
  logic                  hold_last;
  logic                  single_lane;
  logic                  out_hs;
  logic                  in_hs;
  logic                  empty_pkt;
  logic [7:0]            sel_byte;
  logic [1:0]            pkt_inc;

  assign lowest_bit  = remaining & (~remaining + KEEP_WIDTH'(1));
  assign single_lane = (remaining != '0) && ((remaining & (remaining - KEEP_WIDTH'(1))) == '0);

  // Scanning from the top lane down leaves the lowest kept lane as the final assignment.
  always_comb begin
    sel_byte = '0;
    for (int i = KEEP_WIDTH - 1; i >= 0; i--) begin
      if (remaining[i]) sel_byte = hold_data[8*i +: 8];
    end
  end

  assign BYTE_tdata  = sel_byte;
  assign BYTE_tvalid = (remaining != '0);
  assign BYTE_tlast  = hold_last && single_lane;

  // Refill is allowed in the same cycle the final byte leaves, so beats run back-to-back.
  assign AXIS_H2C_tready = (remaining == '0) || (BYTE_tready && single_lane);

  assign out_hs    = BYTE_tvalid && BYTE_tready;
  assign in_hs     = AXIS_H2C_tvalid && AXIS_H2C_tready;
  assign empty_pkt = in_hs && (AXIS_H2C_tkeep == '0) && AXIS_H2C_tlast;
  assign pkt_inc   = {1'b0, out_hs && BYTE_tlast} + {1'b0, empty_pkt};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_data <= '0;
      remaining <= '0;
      hold_last <= 1'b0;
    end else if (in_hs) begin
      hold_data <= AXIS_H2C_tdata;
      remaining <= AXIS_H2C_tkeep;
      hold_last <= AXIS_H2C_tlast;
    end else if (out_hs) begin
      remaining <= remaining & ~lowest_bit;
    end
  end

  // A clear coinciding with an increment takes priority and leaves the counters at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_count   <= '0;
      packet_count <= '0;
    end else if (stats_clear) begin
      byte_count   <= '0;
      packet_count <= '0;
    end else begin
      if (out_hs) byte_count <= byte_count + COUNT_WIDTH'(1);
      packet_count <= packet_count + COUNT_WIDTH'(pkt_inc);
    end
  end

endmodule
